// File: rtl/music_sched.sv
// Buzzer music scheduler: latches four song requests, grants one at a time by fixed priority,
// paces the address counter at TICK_DIV and enforces a silent gap. Optional macro: MUSIC_PREEMPT_EN.
module music_sched #(
    parameter int TICK_DIV   = 4096,
    parameter int GAP_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       cancel,
    input  logic       song_end,
    output logic [1:0] sel,
    output logic       step,
    output logic       cnt_rst,
    output logic       busy,
    output logic [3:0] ack,
    output logic [3:0] done
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, LOAD, PRIME, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    sel_q, sel_d;
    logic          step_q, step_d;
    logic          cnt_rst_q, cnt_rst_d;
    logic          busy_q, busy_d;
    logic [3:0]    ack_q, ack_d;
    logic [3:0]    done_q, done_d;

    logic          grant_valid;
    logic [1:0]    grant_idx;
    logic          preempt;
    logic          grant_now;
    logic [3:0]    req_eff;

    // Lowest pending index wins.
    always_comb begin
        grant_valid = |pending_q;
        grant_idx   = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) grant_idx = 2'(i);
        end
    end

`ifdef MUSIC_PREEMPT_EN
    assign preempt = grant_valid && (grant_idx < sel_q);
`else
    assign preempt = 1'b0;
`endif

    assign grant_now = ((state_q == IDLE) && grant_valid) ||
                       (((state_q == PRIME) || (state_q == PLAY)) && preempt);

    always_comb begin
        state_d   = state_q;
        tick_d    = '0;
        gap_d     = '0;
        sel_d     = sel_q;
        step_d    = 1'b0;
        cnt_rst_d = 1'b0;
        ack_d     = '0;
        done_d    = '0;

        // A re-request of the song currently being loaded or played is dropped.
        req_eff = req;
        if ((state_q == LOAD) || (state_q == PRIME) || (state_q == PLAY)) begin
            req_eff[sel_q] = 1'b0;
        end
        pending_d = pending_q | req_eff;

        if (cancel) begin
            state_d   = IDLE;
            pending_d = '0;
            cnt_rst_d = (state_q != IDLE);
        end else if (grant_now) begin
            // Clearing after the OR also absorbs a same-cycle request for the granted song.
            state_d              = LOAD;
            pending_d[grant_idx] = 1'b0;
            sel_d                = grant_idx;
            cnt_rst_d            = 1'b1;
            ack_d[grant_idx]     = 1'b1;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                LOAD:  state_d = PRIME;
                PRIME: state_d = PLAY;
                PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        if (song_end) begin
                            done_d[sel_q] = 1'b1;
                            state_d       = GAP;
                        end else begin
                            step_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                GAP: begin
                    // First GAP cycle coincides with the done pulse, hence the count to GAP_CYCLES.
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            tick_q    <= '0;
            gap_q     <= '0;
            sel_q     <= '0;
            step_q    <= 1'b0;
            cnt_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            gap_q     <= gap_d;
            sel_q     <= sel_d;
            step_q    <= step_d;
            cnt_rst_q <= cnt_rst_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign sel     = sel_q;
    assign step    = step_q;
    assign cnt_rst = cnt_rst_q;
    assign busy    = busy_q;
    assign ack     = ack_q;
    assign done    = done_q;

endmodule

// File: tb/tb_music_sched.sv
// Self-checking bench for music_sched (TICK_DIV=4, GAP_CYCLES=3); ack/done events go through a scoreboard.
module tb_music_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       cancel;
    logic       song_end;
    logic [1:0] sel;
    logic       step;
    logic       cnt_rst;
    logic       busy;
    logic [3:0] ack;
    logic [3:0] done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        bit         is_done;
        logic [3:0] val;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [3:0] mon_v;

    music_sched #(.TICK_DIV(4), .GAP_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cancel   (cancel),
        .song_end (song_end),
        .sel      (sel),
        .step     (step),
        .cnt_rst  (cnt_rst),
        .busy     (busy),
        .ack      (ack),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every ack/done pulse must match the head of the expectation queue in value and cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mon_v = (k == 0) ? ack : done;
            if (mon_v !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_%s cyc=%0d got=%b required=none",
                             (k == 0) ? "ack" : "done", cyc, mon_v);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_done !== (k == 1) || mon_e.val !== mon_v || mon_e.at != cyc) begin
                        errors++;
                        $display("FAIL event got %s=%b@%0d required %s=%b@%0d",
                                 (k == 0) ? "ack" : "done", mon_v, cyc,
                                 mon_e.is_done ? "done" : "ack", mon_e.val, mon_e.at);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int at, input bit is_done, input logic [3:0] val);
        ev_t e;
        e.at = at; e.is_done = is_done; e.val = val;
        exp_q.push_back(e);
    endtask

    // Drives a one-cycle req captured at the next edge; returns that edge number.
    task automatic send_req(input logic [3:0] v, output int b);
        req = v;
        b   = cyc + 1;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_reset;
        int b;
        rst = 1'b1; req = '0; cancel = 1'b0; song_end = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (sel !== 2'd0)     begin errors++; $display("FAIL reset_sel got=%0d required=0", sel); end
        checks++; if (step !== 1'b0)    begin errors++; $display("FAIL reset_step got=%b required=0", step); end
        checks++; if (cnt_rst !== 1'b0) begin errors++; $display("FAIL reset_cnt_rst got=%b required=0", cnt_rst); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_idle_busy got=%b required=0", busy); end

        // Asynchronous reset in the middle of PLAY, on a step cycle.
        send_req(4'b0010, b);
        push_ev(b + 1, 1'b0, 4'b0010);
        wait_until(b + 7);
        checks++; if (step !== 1'b1) begin errors++; $display("FAIL pre_reset_step got=%b required=1", step); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL async_busy got=%b required=0", busy); end
        checks++; if (step !== 1'b0)    begin errors++; $display("FAIL async_step got=%b required=0", step); end
        checks++; if (sel !== 2'd0)     begin errors++; $display("FAIL async_sel got=%0d required=0", sel); end
        checks++; if (ack !== 4'd0 || done !== 4'd0 || cnt_rst !== 1'b0) begin
            errors++; $display("FAIL async_pulses got ack=%b done=%b cnt_rst=%b required=0", ack, done, cnt_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b required=0", busy); end
    endtask

    task automatic test_single;
        int b;
        send_req(4'b0100, b);
        push_ev(b + 1, 1'b0, 4'b0100);
        push_ev(b + 19, 1'b1, 4'b0100);
        wait_until(b + 1);
        checks++; if (sel !== 2'd2)     begin errors++; $display("FAIL single_sel got=%0d required=2", sel); end
        checks++; if (cnt_rst !== 1'b1) begin errors++; $display("FAIL single_cnt_rst got=%b required=1", cnt_rst); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy got=%b required=1", busy); end
        for (int s = 2; s <= 16; s++) begin
            wait_until(b + s);
            checks++;
            if (step !== ((s == 7) || (s == 11) || (s == 15))) begin
                errors++; $display("FAIL single_step cyc=+%0d got=%b required=%b", s, step, (s == 7) || (s == 11) || (s == 15));
            end
        end
        song_end = 1'b1;
        wait_until(b + 19);
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL single_end_step got=%b required=0", step); end
        song_end = 1'b0;
        wait_until(b + 22);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy got=%b required=1", busy); end
        wait_until(b + 23);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b required=0", busy); end
        checks++; if (sel !== 2'd2)  begin errors++; $display("FAIL single_sel_hold got=%0d required=2", sel); end
        wait_until(b + 26);
    endtask

    task automatic test_simultaneous;
        int b;
        song_end = 1'b1;
        send_req(4'b1010, b);
        push_ev(b + 1,  1'b0, 4'b0010);
        push_ev(b + 7,  1'b1, 4'b0010);
        push_ev(b + 12, 1'b0, 4'b1000);
        push_ev(b + 18, 1'b1, 4'b1000);
        wait_until(b + 1);
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL simul_sel_first got=%0d required=1", sel); end
        wait_until(b + 12);
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL simul_sel_second got=%0d required=3", sel); end
        wait_until(b + 19);
        song_end = 1'b0;
        wait_until(b + 22);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle got=%b required=0", busy); end
        wait_until(b + 25);
    endtask

    task automatic test_cancel;
        int b;
        send_req(4'b0001, b);
        push_ev(b + 1, 1'b0, 4'b0001);
        wait_until(b + 5);
        cancel = 1'b1; req = 4'b0001;
        @(negedge clk);
        cancel = 1'b0; req = 4'b0000;
        checks++; if (cnt_rst !== 1'b1) begin errors++; $display("FAIL cancel_cnt_rst got=%b required=1", cnt_rst); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL cancel_busy got=%b required=0", busy); end
        @(negedge clk);
        checks++; if (cnt_rst !== 1'b0) begin errors++; $display("FAIL cancel_cnt_rst_len got=%b required=0", cnt_rst); end
        wait_until(b + 20);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL cancel_stays_idle got=%b required=0", busy); end
    endtask

    task automatic test_rerequest;
        int b;
        send_req(4'b0100, b);
        push_ev(b + 1,  1'b0, 4'b0100);
        push_ev(b + 11, 1'b1, 4'b0100);
        wait_until(b + 5);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_until(b + 8);
        song_end = 1'b1;
        wait_until(b + 12);
        song_end = 1'b0;
        wait_until(b + 15);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rereq_idle got=%b required=0", busy); end
        wait_until(b + 25);
    endtask

    task automatic test_preempt;
        int b;
        send_req(4'b1000, b);
        push_ev(b + 1, 1'b0, 4'b1000);
`ifdef MUSIC_PREEMPT_EN
        push_ev(b + 7,  1'b0, 4'b0001);
        push_ev(b + 13, 1'b1, 4'b0001);
`else
        push_ev(b + 11, 1'b1, 4'b1000);
        push_ev(b + 16, 1'b0, 4'b0001);
        push_ev(b + 22, 1'b1, 4'b0001);
`endif
        wait_until(b + 5);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_until(b + 8);
        song_end = 1'b1;
        wait_until(b + 23);
        song_end = 1'b0;
        wait_until(b + 28);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preempt_idle got=%b required=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_cancel();
        test_rerequest();
        test_preempt();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_events got=%0d outstanding required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
